// File: rtl/seven_segment_scheduler.sv
// Time-shares the seven-segment display between four measurement sources and a setting source:
// latch value, convert to BCD by double-dabble, then issue fraction/integer/mode register writes.
module seven_segment_scheduler #(
  parameter int         REFRESH_CYCLES = 1000,
  parameter logic [3:0] MODE_BASE      = 4'hA
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        Mode_Button,
  input  logic        Setting_Active,
  input  logic [39:0] Src_Int,
  input  logic [27:0] Src_Frac,
  input  logic [9:0]  Set_Int,
  input  logic [6:0]  Set_Frac,
  output logic        Wr_Valid,
  input  logic        Wr_Ready,
  output logic [1:0]  Wr_Addr,
  output logic [11:0] Wr_Data,
  output logic [1:0]  Mode_Sel,
  output logic        Busy,
  output logic [2:0]  fsm_state
);

  // Write port: a write is taken on any rising edge where Wr_Valid && Wr_Ready; while
  // Wr_Ready is low, Wr_Valid, Wr_Addr and Wr_Data hold their values.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CONVERT = 3'd2,
    WR_FRAC = 3'd3,
    WR_INT  = 3'd4,
    WR_MODE = 3'd5
  } state_t;

  localparam int TW = $clog2(REFRESH_CYCLES);

  state_t          state;
  logic [TW-1:0]   timer;
  logic            pending;
  logic            setting_q;
  logic [3:0]      cnt;
  logic [21:0]     int_sr;   // {12b BCD, 10b binary}
  logic [17:0]     frac_sr;  // {8b BCD, 10b binary}
  logic [3:0]      mode_code;
  logic [21:0]     int_next;
  logic [17:0]     frac_next;
  logic [9:0]      int_in;
  logic [6:0]      frac_in;
  logic            wrap;
  logic            event_set;

  function automatic logic [21:0] dd_int(input logic [21:0] sr);
    logic [21:0] t;
    t = sr;
    for (int i = 0; i < 3; i++)
      if (t[10+4*i +: 4] >= 4'd5) t[10+4*i +: 4] = t[10+4*i +: 4] + 4'd3;
    return {t[20:0], 1'b0};
  endfunction

  function automatic logic [17:0] dd_frac(input logic [17:0] sr);
    logic [17:0] t;
    t = sr;
    for (int i = 0; i < 2; i++)
      if (t[10+4*i +: 4] >= 4'd5) t[10+4*i +: 4] = t[10+4*i +: 4] + 4'd3;
    return {t[16:0], 1'b0};
  endfunction

  assign int_next  = dd_int(int_sr);
  assign frac_next = dd_frac(frac_sr);
  assign int_in    = Setting_Active ? Set_Int  : Src_Int[Mode_Sel*10 +: 10];
  assign frac_in   = Setting_Active ? Set_Frac : Src_Frac[Mode_Sel*7 +: 7];
  assign wrap      = (timer == TW'(REFRESH_CYCLES - 1));
  // Several simultaneous causes collapse into one pending refresh.
  assign event_set = wrap | (Mode_Button & ~Setting_Active) | (Setting_Active ^ setting_q);
  assign fsm_state = state;

  always_ff @(posedge HCLK) begin
    setting_q <= Setting_Active;
    if (HRESET) begin
      state     <= IDLE;
      timer     <= '0;
      pending   <= 1'b1;
      Mode_Sel  <= 2'd0;
      Wr_Valid  <= 1'b0;
      Wr_Addr   <= 2'd0;
      Wr_Data   <= 12'd0;
      Busy      <= 1'b0;
      cnt       <= 4'd0;
      int_sr    <= '0;
      frac_sr   <= '0;
      mode_code <= 4'd0;
    end else begin
      timer   <= wrap ? '0 : timer + 1'b1;
      pending <= event_set | (pending & (state != LOAD));
      if (Mode_Button && !Setting_Active) Mode_Sel <= Mode_Sel + 2'd1;
      case (state)
        IDLE: if (pending) begin
          state <= LOAD;
          Busy  <= 1'b1;
        end
        LOAD: begin
          int_sr    <= {12'd0, (int_in > 10'd999) ? 10'd999 : int_in};
          frac_sr   <= {8'd0, 3'd0, (frac_in > 7'd99) ? 7'd99 : frac_in};
          mode_code <= Setting_Active ? 4'hE : MODE_BASE + {2'b00, Mode_Sel};
          cnt       <= 4'd0;
          state     <= CONVERT;
        end
        CONVERT: begin
          int_sr  <= int_next;
          frac_sr <= frac_next;
          cnt     <= cnt + 4'd1;
          if (cnt == 4'd9) begin
            state    <= WR_FRAC;
            Wr_Valid <= 1'b1;
            Wr_Addr  <= 2'd0;
            Wr_Data  <= {4'd0, frac_next[17:10]};
          end
        end
        WR_FRAC: if (Wr_Ready) begin
          state   <= WR_INT;
          Wr_Addr <= 2'd1;
          Wr_Data <= int_sr[21:10];
        end
        WR_INT: if (Wr_Ready) begin
          state   <= WR_MODE;
          Wr_Addr <= 2'd2;
          Wr_Data <= {8'd0, mode_code};
        end
        WR_MODE: if (Wr_Ready) begin
          state    <= IDLE;
          Wr_Valid <= 1'b0;
          Busy     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          Wr_Valid <= 1'b0;
          Busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
